// File: rtl/hps_reset_pkg.sv
// Shared encodings and helpers for the HPS reset sequencer.
// State and kind codes stay plain constants so legacy tooling can decode them.
package hps_reset_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ASSERT    = 3'd1;
    localparam logic [2:0] ST_WAIT_DOWN = 3'd2;
    localparam logic [2:0] ST_WAIT_UP   = 3'd3;
    localparam logic [2:0] ST_COOLDOWN  = 3'd4;

    localparam logic KIND_COLD = 1'b0;
    localparam logic KIND_WARM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hps_reset_rr_arb.sv
// Combinational round-robin arbiter: the search begins at ptr and wraps
// around N_REQ, returning the first set request as one-hot plus its index.
module hps_reset_rr_arb
    import hps_reset_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int p;
        p = int'(base) + off;
        if (p >= N_REQ) begin
            p = p - N_REQ;
        end else begin
            p = p;
        end
        return IDX_W'(p);
    endfunction

    logic hit_s;

    // First requester at or after the pointer wins.
    always_comb begin
        grant = {N_REQ{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        hit_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            hit_s                 = !any && req_vec[wrap_idx(ptr, i)];
            grant[wrap_idx(ptr, i)] = grant[wrap_idx(ptr, i)] | hit_s;
            idx                   = hit_s ? wrap_idx(ptr, i) : idx;
            any                   = any | hit_s;
        end
    end

endmodule

// File: rtl/hps_reset_sequencer.sv
// Arbitrates cold/warm HPS reset requests, drives fixed-width reset pulses,
// then follows hps_fpga_reset_n down and up (with timeouts) before a cooldown.
module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int COLD_PULSE   = 6,
    parameter int WARM_PULSE   = 2,
    parameter int WAIT_TIMEOUT = 1000000,
    parameter int COOLDOWN     = 16,
    parameter int CNT_W        = 20
) (
    input  logic             clock_clk,
    input  logic             reset_reset,
    input  logic [N_REQ-1:0] req_cold,
    input  logic [N_REQ-1:0] req_warm,
    output logic [N_REQ-1:0] req_grant,
    input  logic             hps_fpga_reset_n,
    output logic             hps_cold_reset,
    output logic             hps_warm_reset,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clear
);

    localparam int     IDX_W   = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

    generate
        if (longint'(COLD_PULSE - 1) > CNT_MAX || longint'(WARM_PULSE - 1) > CNT_MAX ||
            longint'(WAIT_TIMEOUT - 1) > CNT_MAX || longint'(COOLDOWN - 1) > CNT_MAX) begin : g_cnt_w_check
            $fatal(1, "hps_reset_sequencer: CNT_W too narrow for a counter load value");
        end
        if (N_REQ < 1 || N_REQ > 8) begin : g_n_req_check
            $fatal(1, "hps_reset_sequencer: N_REQ must be 1..8");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LOAD_COLD = CNT_W'(COLD_PULSE - 1);
    localparam logic [CNT_W-1:0] LOAD_WARM = CNT_W'(WARM_PULSE - 1);
    localparam logic [CNT_W-1:0] LOAD_WAIT = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOAD_COOL = CNT_W'(COOLDOWN - 1);

    logic             hfr_meta_r;
    logic             hfr_s;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_dec_s;
    logic             cnt_zero_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] grant_nxt_s;
    logic             cold_r;
    logic             cold_nxt_s;
    logic             warm_r;
    logic             warm_nxt_s;
    logic             busy_r;
    logic             timeout_err_r;
    logic             err_set_s;

    logic             kind_s;
    logic [N_REQ-1:0] arb_req_s;
    logic [N_REQ-1:0] arb_grant_s;
    logic [IDX_W-1:0] arb_idx_s;
    logic             arb_any_s;

    // Cold requests shadow warm ones entirely, so only one vector is arbitrated.
    assign kind_s    = (|req_cold) ? KIND_COLD : KIND_WARM;
    assign arb_req_s = (|req_cold) ? req_cold : req_warm;

    hps_reset_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_vec (arb_req_s),
        .ptr     (ptr_r),
        .grant   (arb_grant_s),
        .idx     (arb_idx_s),
        .any     (arb_any_s)
    );

    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
    assign cnt_dec_s  = cnt_zero_s ? {CNT_W{1'b0}} : (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1});

    // Two-flop synchronizer; idles high so a reset-release does not look like HPS reset.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hfr_meta_r <= 1'b1;
            hfr_s      <= 1'b1;
        end else begin
            hfr_meta_r <= hps_fpga_reset_n;
            hfr_s      <= hfr_meta_r;
        end
    end

    // Next-state, counter and output-pulse decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_dec_s;
        ptr_nxt_s   = ptr_r;
        grant_nxt_s = {N_REQ{1'b0}};
        cold_nxt_s  = cold_r;
        warm_nxt_s  = warm_r;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cold_nxt_s = 1'b0;
                warm_nxt_s = 1'b0;
                if (arb_any_s) begin
                    state_nxt_s = ST_ASSERT;
                    grant_nxt_s = arb_grant_s;
                    if (int'(arb_idx_s) == N_REQ - 1) begin
                        ptr_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        ptr_nxt_s = arb_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                    if (kind_s == KIND_COLD) begin
                        cold_nxt_s = 1'b1;
                        cnt_nxt_s  = LOAD_COLD;
                    end else begin
                        warm_nxt_s = 1'b1;
                        cnt_nxt_s  = LOAD_WARM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (cnt_zero_s) begin
                    cold_nxt_s  = 1'b0;
                    warm_nxt_s  = 1'b0;
                    cnt_nxt_s   = LOAD_WAIT;
                    state_nxt_s = ST_WAIT_DOWN;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_WAIT_DOWN: begin
                if (!hfr_s) begin
                    cnt_nxt_s   = LOAD_WAIT;
                    state_nxt_s = ST_WAIT_UP;
                end else if (cnt_zero_s) begin
                    err_set_s   = 1'b1;
                    cnt_nxt_s   = LOAD_COOL;
                    state_nxt_s = ST_COOLDOWN;
                end else begin
                    state_nxt_s = ST_WAIT_DOWN;
                end
            end
            ST_WAIT_UP: begin
                if (hfr_s) begin
                    cnt_nxt_s   = LOAD_COOL;
                    state_nxt_s = ST_COOLDOWN;
                end else if (cnt_zero_s) begin
                    err_set_s   = 1'b1;
                    cnt_nxt_s   = LOAD_COOL;
                    state_nxt_s = ST_COOLDOWN;
                end else begin
                    state_nxt_s = ST_WAIT_UP;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COOLDOWN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                cold_nxt_s  = 1'b0;
                warm_nxt_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset truncates any pulse in flight.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            ptr_r         <= {IDX_W{1'b0}};
            grant_r       <= {N_REQ{1'b0}};
            cold_r        <= 1'b0;
            warm_r        <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            grant_r <= grant_nxt_s;
            cold_r  <= cold_nxt_s;
            warm_r  <= warm_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            // A new timeout takes priority over a simultaneous clear.
            if (err_set_s) begin
                timeout_err_r <= 1'b1;
            end else if (err_clear) begin
                timeout_err_r <= 1'b0;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign req_grant      = grant_r;
    assign hps_cold_reset = cold_r;
    assign hps_warm_reset = warm_r;
    assign busy           = busy_r;
    assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer: grants, pulse widths, round-robin,
// timeouts with err_clear, asynchronous reset and input glitch immunity.
module tb_hps_reset_sequencer;

    logic       clock_clk = 1'b0;
    logic       reset_reset;
    logic [3:0] req_cold;
    logic [3:0] req_warm;
    logic [3:0] req_grant;
    logic       hps_fpga_reset_n;
    logic       hps_cold_reset;
    logic       hps_warm_reset;
    logic       busy;
    logic       timeout_err;
    logic       err_clear;

    int total = 0;
    int bad   = 0;

    hps_reset_sequencer #(
        .N_REQ        (4),
        .COLD_PULSE   (6),
        .WARM_PULSE   (2),
        .WAIT_TIMEOUT (100),
        .COOLDOWN     (16),
        .CNT_W        (20)
    ) dut (
        .clock_clk        (clock_clk),
        .reset_reset      (reset_reset),
        .req_cold         (req_cold),
        .req_warm         (req_warm),
        .req_grant        (req_grant),
        .hps_fpga_reset_n (hps_fpga_reset_n),
        .hps_cold_reset   (hps_cold_reset),
        .hps_warm_reset   (hps_warm_reset),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .err_clear        (err_clear)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_clk);
        #1;
    endtask

    // Waits for a grant, checks it and the pulse, optionally plays the HPS side.
    task automatic serve(input string tag, input logic [3:0] exp_grant, input logic exp_cold,
                         input bit hps_resp);
        int n;
        int pw;
        int bl;
        n = 0;
        do begin
            step();
            n++;
        end while (req_grant == 4'd0 && n < 40);
        chk({tag, ".latency"}, 32'(n), 32'd1);
        chk({tag, ".grant"}, 32'(req_grant), 32'(exp_grant));
        chk({tag, ".kind"}, 32'({hps_cold_reset, hps_warm_reset}), exp_cold ? 32'd2 : 32'd1);
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        pw = 0;
        while ((hps_cold_reset || hps_warm_reset) && pw < 40) begin
            pw++;
            step();
            if (pw == 1) chk({tag, ".grant_1cyc"}, 32'(req_grant), 32'd0);
        end
        chk({tag, ".pulse_w"}, 32'(pw), exp_cold ? 32'd6 : 32'd2);
        if (hps_resp) begin
            repeat (4) step();
            hps_fpga_reset_n = 1'b0;
            repeat (50) step();
            hps_fpga_reset_n = 1'b1;
            bl = 0;
            do begin
                step();
                bl++;
            end while (busy && bl < 200);
            // 2 sync stages + 1 exit edge + 16 cooldown cycles
            chk({tag, ".busy_release"}, 32'(bl), 32'd19);
            chk({tag, ".no_timeout"}, 32'(timeout_err), 32'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic count_to_err(input string tag);
        int n;
        n = 0;
        while (!timeout_err && n < 300) begin
            step();
            n++;
        end
        chk({tag, ".to_cycles"}, 32'(n), 32'd100);
        chk({tag, ".busy_in_cool"}, 32'(busy), 32'd1);
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        reset_reset      = 1'b1;
        req_cold         = 4'd0;
        req_warm         = 4'd0;
        hps_fpga_reset_n = 1'b1;
        err_clear        = 1'b0;
        #3;
        chk("rst.outputs", 32'({req_grant, hps_cold_reset, hps_warm_reset, busy, timeout_err}), 32'd0);
        repeat (3) step();
        reset_reset = 1'b0;
        step();
        chk("rst.idle", 32'({req_grant, hps_cold_reset, hps_warm_reset, busy, timeout_err}), 32'd0);

        // Warm request from requester 1
        req_warm = 4'b0010;
        serve("warm1", 4'b0010, 1'b0, 1'b1);
        req_warm = 4'd0;

        // Cold beats warm in the same cycle; warm follows after cooldown
        req_cold = 4'b1000;
        req_warm = 4'b0001;
        serve("cold_pri", 4'b1000, 1'b1, 1'b1);
        req_cold = 4'd0;
        serve("warm_after", 4'b0001, 1'b0, 1'b1);
        req_warm = 4'd0;

        // One-cycle glitch on hps_fpga_reset_n while idle
        hps_fpga_reset_n = 1'b0;
        step();
        hps_fpga_reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("glitch.quiet", 32'({req_grant, hps_cold_reset, hps_warm_reset, busy, timeout_err}), 32'd0);
        end

        // HPS never responds: timeout, clear, then set-beats-clear
        req_warm = 4'b0001;
        serve("to1", 4'b0001, 1'b0, 1'b0);
        req_warm = 4'd0;
        count_to_err("to1");
        wait_idle("to1");
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("to1.cleared", 32'(timeout_err), 32'd0);
        req_warm = 4'b0001;
        serve("to2", 4'b0001, 1'b0, 1'b0);
        req_warm  = 4'd0;
        err_clear = 1'b1;
        count_to_err("to2");
        err_clear = 1'b0;
        step();
        chk("to2.sticky", 32'(timeout_err), 32'd1);
        wait_idle("to2");

        // Reset on the 3rd cycle of a cold pulse
        req_cold = 4'b0100;
        begin
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (req_grant == 4'd0 && n < 40);
            chk("rstmid.grant", 32'(req_grant), 32'b0100);
        end
        step();
        step();
        chk("rstmid.pulse_on", 32'(hps_cold_reset), 32'd1);
        #1;
        reset_reset = 1'b1;
        #1;
        chk("rstmid.async", 32'({hps_cold_reset, hps_warm_reset, busy, timeout_err, req_grant}), 32'd0);
        req_cold = 4'd0;
        #3;
        reset_reset = 1'b0;
        step();
        // Pointer back at 0: requesters 0 and 3 contend, 0 must win
        req_cold = 4'b1001;
        serve("post_rst", 4'b0001, 1'b1, 1'b1);
        req_cold = 4'd0;

        reset_reset = 1'b1;
        #2;
        reset_reset = 1'b0;
        step();

        // Round-robin fairness with all warm requests held
        req_warm = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve($sformatf("rr%0d", i), rr_exp[i], 1'b0, 1'b1);
        end
        req_warm = 4'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
